card_deal_arbiter: RTL
======================

// Module: card_deal_arbiter
// PURPOSE
//  Shares the single card-source LUT (pip -> number) between two requesters, player (P) and dealer (D).
//  Arbitrates draw requests round-robin, issues a one-cycle pip, and waits for a legal card (1..13).
//  Delivers the card tagged with owner and hand slot, and enforces the 5-card hand limit.
//  Sits between the ten-thirty game FSM and the lut instance; it is the only driver of lut pip.
// PARAMETERS
//  LUT_LATENCY  1   cycles from lut_pip high to first cycle lut_number may be sampled (>=1)
//  MAX_CARDS    5   cards per hand; requests beyond this are rejected
//  TIMEOUT      15  WAIT cycles without a legal card before abort (4-bit counter)
// PORTS
//  clk          in   1  single clock (game-logic clock)
//  rst          in   1  synchronous, active-high reset
//  clr          in   1  new-round pulse: abort in-flight draw, zero both hand counts
//  req_p        in   1  player draw request, level; held until ack_p or rej_p
//  req_d        in   1  dealer draw request, level; held until ack_d or rej_d
//  lut_pip      out  1  one-cycle draw strobe to lut
//  lut_number   in   4  card from lut; 0 = none, 1..13 legal, 14/15 illegal
//  card_valid   out  1  one-cycle pulse: card_value/card_owner/card_slot valid
//  card_owner   out  1  0 = player, 1 = dealer
//  card_value   out  4  delivered card 1..13
//  card_slot    out  3  hand index 0..MAX_CARDS-1 the card occupies
//  ack_p/ack_d  out  1  one-cycle, coincident with card_valid for that owner
//  rej_p/rej_d  out  1  one-cycle: request refused, hand full
//  p_count      out  3  cards in player hand
//  d_count      out  3  cards in dealer hand
//  busy         out  1  high in any state other than IDLE
//  err_timeout  out  1  one-cycle pulse on WAIT timeout
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; last_owner = 1, so the player wins the first tie. rst beats clr.
//  FSM: IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE.
//  IDLE:
//   - Only requesters with count < MAX_CARDS are eligible.
//   - A full requester with req high gets rej_x the next cycle and no grant; rej repeats every 2 cycles while req stays high.
//   - One eligible request: grant it. Both eligible: grant the owner != last_owner.
//   - On grant, latch owner and go to ISSUE.
//  ISSUE: lut_pip = 1 for exactly this cycle; go to WAIT with wait_cnt = 0.
//  WAIT:
//   - wait_cnt increments each cycle. lut_number is sampled only when wait_cnt >= LUT_LATENCY-1.
//   - First sample in 1..13: register it and go to DELIVER. Values 0, 14 and 15 are ignored.
//   - At wait_cnt == TIMEOUT-1 with no legal card: err_timeout pulse, back to IDLE, no delivery, last_owner unchanged.
//   - The requester stays pending, so a retry follows naturally.
//  DELIVER:
//   - card_valid, ack_owner, card_value and card_slot (= owner count before increment) for one cycle.
//   - Owner count += 1; last_owner = owner; go to IDLE.
//  Latency (LUT_LATENCY = 1, lut answers immediately): req sampled cycle N; lut_pip N+1; card_valid N+3.
//  Back-to-back: the earliest next lut_pip is 4 cycles after the previous one.
//  clr in any state: next cycle state = IDLE, counts = 0, lut_pip = 0, no card_valid/ack.
//   - A legal lut_number arriving that cycle is discarded. last_owner resets to 1.
//  Requests dropped mid-transaction are ignored; the card is still delivered to the latched owner.
//  Counts saturate at MAX_CARDS and never wrap. At most one of card_valid/err_timeout/rej_* per owner per cycle.
// TESTING
//  1. Reset, req_p=1, lut_number=7 one cycle after pip -> lut_pip at N+1; card_valid at N+3 with owner 0, value 7, slot 0; p_count=1.
//  2. req_p and req_d both high from reset, lut returns 3,9,4,11 -> owners P,D,P,D; values in order; p_count=d_count=2.
//  3. req_d held with d_count=5 -> rej_d pulses, no lut_pip, d_count stays 5; a concurrent req_p is still served.
//  4. lut_number held 0 (then 14) for 15 WAIT cycles -> err_timeout one cycle; no card_valid; re-issue pip 2 cycles later.
//  5. clr asserted the cycle lut_number=12 arrives in WAIT -> no card_valid; counts 0; busy=0 next cycle.
//  6. rst asserted in DELIVER together with clr -> all outputs 0 next cycle; the next tie is granted to the player.

Source files
------------

// File: rtl/card_deal_arbiter_if.sv
// Game-side and LUT-side signals of the card deal arbiter.
// The arbiter takes the slave modport; the game FSM / LUT side takes the master modport.
interface card_deal_arbiter_if;
    logic       clr;
    logic       req_p;
    logic       req_d;
    logic       lut_pip;
    logic [3:0] lut_number;
    logic       card_valid;
    logic       card_owner;
    logic [3:0] card_value;
    logic [2:0] card_slot;
    logic       ack_p;
    logic       ack_d;
    logic       rej_p;
    logic       rej_d;
    logic [2:0] p_count;
    logic [2:0] d_count;
    logic       busy;
    logic       err_timeout;

    modport slave (
        input  clr, req_p, req_d, lut_number,
        output lut_pip, card_valid, card_owner, card_value, card_slot,
               ack_p, ack_d, rej_p, rej_d, p_count, d_count, busy, err_timeout
    );

    modport master (
        output clr, req_p, req_d, lut_number,
        input  lut_pip, card_valid, card_owner, card_value, card_slot,
               ack_p, ack_d, rej_p, rej_d, p_count, d_count, busy, err_timeout
    );
endinterface

// File: rtl/card_deal_arbiter.sv
// Round-robin arbiter sharing one card LUT between player and dealer.
// Issues a pip, waits for a legal card, delivers it with owner/slot and enforces the hand limit.
module card_deal_arbiter #(
    parameter int LUT_LATENCY = 1,
    parameter int MAX_CARDS   = 5,
    parameter int TIMEOUT     = 15
) (
    input logic                clk,
    input logic                rst,
    card_deal_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
    localparam logic [2:0] CNT_MAX   = 3'(MAX_CARDS);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] value_q, value_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;

    logic [1:0] req;
    logic [1:0] full;
    logic [1:0] eligible;
    logic [1:0] rej;
    logic [2:0] cnt [2];
    logic       legal;
    logic       sample_en;
    logic       grant_owner;
    logic       err_pulse;
    logic       deliver;

    // index 0 = player, 1 = dealer
    assign req       = {bus.req_d, bus.req_p};
    assign legal     = (bus.lut_number != 4'd0) && (bus.lut_number <= 4'd13);
    assign sample_en = ({1'b0, wait_cnt_q} + 5'd1) >= 5'(LUT_LATENCY);
    assign deliver   = (state_q == S_DELIVER);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_owner
            logic [2:0] cnt_q;
            logic       rej_q;
            logic       rej_d;
            logic       inc;

            assign full[gi]     = (cnt_q >= CNT_MAX);
            assign eligible[gi] = req[gi] && !full[gi];
            // refusal toggles so a held request is refused every other cycle
            assign rej_d        = (state_q == S_IDLE) && req[gi] && full[gi] && !rej_q;
            assign inc          = deliver && (owner_q == 1'(gi));
            assign cnt[gi]      = cnt_q;
            assign rej[gi]      = rej_q;

            always_ff @(posedge clk) begin
                if (rst || bus.clr) begin
                    cnt_q <= '0;
                    rej_q <= 1'b0;
                end else begin
                    rej_q <= rej_d;
                    if (inc && (cnt_q < CNT_MAX)) begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            value_q      <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            value_q      <= value_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        value_d      = value_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        err_pulse    = 1'b0;

        // a tie goes to whichever owner was not served last
        if (eligible[0] && eligible[1]) begin
            grant_owner = ~last_owner_q;
        end else begin
            grant_owner = eligible[1];
        end

        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    owner_d = grant_owner;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 4'd1;
                if (sample_en && legal) begin
                    value_d = bus.lut_number;
                    state_d = S_DELIVER;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_pulse = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DELIVER: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.clr) begin
            state_d      = S_IDLE;
            last_owner_d = 1'b1;
            err_pulse    = 1'b0;
        end
    end

    assign bus.lut_pip     = (state_q == S_ISSUE);
    assign bus.card_valid  = deliver;
    assign bus.card_owner  = deliver & owner_q;
    assign bus.card_value  = deliver ? value_q : 4'd0;
    assign bus.card_slot   = deliver ? cnt[owner_q] : 3'd0;
    assign bus.ack_p       = deliver & ~owner_q;
    assign bus.ack_d       = deliver & owner_q;
    assign bus.rej_p       = rej[0];
    assign bus.rej_d       = rej[1];
    assign bus.p_count     = cnt[0];
    assign bus.d_count     = cnt[1];
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.err_timeout = err_pulse;
endmodule
